// File: rtl/fb_scanout.sv
// Framebuffer scan-out address engine: issues BRAM read addresses READ_LAT cycles
// ahead of the pixel, with 2^SCALE_SHIFT replication and frame-synchronous bank swap.
module fb_scanout #(
  parameter int H_RES       = 800,
  parameter int V_RES       = 600,
  parameter int ADDR_WIDTH  = 20,
  parameter int READ_LAT    = 3,
  parameter int SCALE_SHIFT = 0,
  parameter int BANK1_BASE  = 480000
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic signed [15:0]    sx,
  input  logic signed [15:0]    sy,
  input  logic                  frame,
  input  logic                  swap_req,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  addr_en,
  output logic                  pix_valid,
  output logic                  bank,
  output logic                  swap_ack
);

  localparam logic [ADDR_WIDTH-1:0] W_A      = ADDR_WIDTH'(H_RES >> SCALE_SHIFT);
  localparam logic [ADDR_WIDTH-1:0] BASE1    = ADDR_WIDTH'(BANK1_BASE);
  localparam logic signed [15:0]    SX_FIRST = 16'(-READ_LAT);
  localparam logic signed [15:0]    SX_LAST  = 16'(H_RES - READ_LAT - 1);
  localparam logic signed [15:0]    SY_LAST  = 16'(V_RES - 1);
  localparam logic [2:0]            SUB_MAX  = 3'((1 << SCALE_SHIFT) - 1);
  localparam logic [15:0]           Y_MASK   = 16'((1 << SCALE_SHIFT) - 1);

  logic                  pending_reg;
  logic                  armed_reg;
  logic [ADDR_WIDTH-1:0] col_reg;
  logic [2:0]            sub_reg;
  logic [ADDR_WIDTH-1:0] line_base_reg;

  logic                  in_window;
  logic                  line_start;
  logic                  line_end;
  logic                  row_done;
  logic                  issue;
  logic                  do_swap;
  logic                  bank_next;
  logic [15:0]           sy_u;
  logic [ADDR_WIDTH-1:0] col_cur;
  logic [2:0]            sub_cur;

  assign sy_u       = sy;
  assign in_window  = (sy >= 16'sd0) && (sy <= SY_LAST) && (sx >= SX_FIRST) && (sx <= SX_LAST);
  assign line_start = (sx == SX_FIRST);
  assign line_end   = (sx == SX_LAST);
  // The last line of each replicated row group moves the base on; others repeat the row.
  assign row_done   = ((sy_u & Y_MASK) == Y_MASK);
  assign issue      = armed_reg && in_window;
  assign do_swap    = frame && (pending_reg || swap_req);
  assign bank_next  = bank ^ do_swap;
  assign col_cur    = line_start ? '0 : col_reg;
  assign sub_cur    = line_start ? '0 : sub_reg;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr          <= '0;
      addr_en       <= 1'b0;
      bank          <= 1'b0;
      swap_ack      <= 1'b0;
      pending_reg   <= 1'b0;
      armed_reg     <= 1'b0;
      col_reg       <= '0;
      sub_reg       <= '0;
      line_base_reg <= '0;
    end else begin
      swap_ack <= do_swap;
      addr_en  <= issue;
      if (frame) begin
        armed_reg     <= 1'b1;
        pending_reg   <= 1'b0;
        bank          <= bank_next;
        line_base_reg <= bank_next ? BASE1 : '0;
      end else begin
        pending_reg <= pending_reg | swap_req;
        if (issue && line_end && row_done)
          line_base_reg <= line_base_reg + W_A;
      end
      if (issue) begin
        addr <= line_base_reg + col_cur;
        if (sub_cur == SUB_MAX) begin
          col_reg <= col_cur + 1'b1;
          sub_reg <= '0;
        end else begin
          col_reg <= col_cur;
          sub_reg <= sub_cur + 3'd1;
        end
      end
    end
  end

  // addr_en already carries one cycle of the read latency; the rest is a shift chain.
  generate
    if (READ_LAT == 1) begin : g_no_dly
      assign pix_valid = addr_en;
    end else begin : g_dly
      logic [READ_LAT-2:0] vld_pipe_reg;
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          vld_pipe_reg <= '0;
        end else begin
          vld_pipe_reg[0] <= addr_en;
          for (int i = 1; i < READ_LAT - 1; i++)
            vld_pipe_reg[i] <= vld_pipe_reg[i-1];
        end
      end
      assign pix_valid = vld_pipe_reg[READ_LAT-2];
    end
  endgenerate

endmodule
